// File: rtl/tilexy_pkg.sv
// Shared tile-link definitions: write-request record widths, requester indices,
// the egress arbiter state encoding and small index helpers.
package tilexy_pkg;

  localparam int WRREQ_PAYLOAD_W = 680;
  localparam int WRREQ_W         = WRREQ_PAYLOAD_W + 2;  // payload plus snd/extra

  localparam logic [1:0] REQ_LOCAL = 2'd0;
  localparam logic [1:0] REQ_THRU  = 2'd1;
  localparam logic [1:0] REQ_MISS  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_HOLD  = 2'd2
  } arb_state_e;

  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    rr_next = (idx == REQ_MISS) ? REQ_LOCAL : idx + 2'd1;
  endfunction

  function automatic logic [1:0] oh_to_idx(input logic [2:0] oh);
    oh_to_idx = oh[2] ? REQ_MISS : (oh[1] ? REQ_THRU : REQ_LOCAL);
  endfunction

endpackage

// File: rtl/tilexy_link_arb_if.sv
// Requester and link-side signals of one mesh-link egress arbiter.
// Handshake: req_grant[i] is a same-cycle accept of the beat presented with
// req_valid[i]; the requester pops it at the clock edge. No ready on the link
// side: flow control is purely by credits, with link_stall gating new bursts.
interface tilexy_link_arb_if #(
  parameter int W  = tilexy_pkg::WRREQ_W,
  parameter int CW = 4
);
  logic [2:0]        req_valid;
  logic [2:0]        req_last;
  logic [2:0][W-1:0] req_data;
  logic [2:0]        req_grant;
  logic              link_valid;
  logic [W-1:0]      link_data;
  logic              credit_ret;
  logic              link_stall;
  logic [CW-1:0]     credits;
  logic              cred_err;

  modport slave (
    input  req_valid, req_last, req_data, credit_ret, link_stall,
    output req_grant, link_valid, link_data, credits, cred_err
  );

  modport master (
    output req_valid, req_last, req_data, credit_ret, link_stall,
    input  req_grant, link_valid, link_data, credits, cred_err
  );
endinterface

// File: rtl/tilexy_rr3.sv
// 3-way round-robin picker: search starts at ptr_i; any requesting bit set in
// ovr_i wins outright. Output is one-hot (or zero when nothing requests).
module tilexy_rr3 (
  input  logic [2:0] req_i,
  input  logic [1:0] ptr_i,
  input  logic [2:0] ovr_i,
  output logic [2:0] gnt_o
);
  logic [2:0] ovr_req;
  logic [2:0] rot;
  logic [2:0] first;

  assign ovr_req = ovr_i & req_i;

  // Rotate so that rot[0] is the requester at the pointer, then take lowest set bit.
  always_comb begin
    unique case (ptr_i)
      2'd1:    rot = {req_i[0], req_i[2], req_i[1]};
      2'd2:    rot = {req_i[1], req_i[0], req_i[2]};
      default: rot = req_i;
    endcase
    first = rot & (~rot + 3'd1);
  end

  always_comb begin
    if (|ovr_req) begin
      gnt_o = ovr_req & (~ovr_req + 3'd1);
    end else begin
      unique case (ptr_i)
        2'd1:    gnt_o = {first[1], first[0], first[2]};
        2'd2:    gnt_o = {first[0], first[2], first[1]};
        default: gnt_o = first;
      endcase
    end
  end
endmodule

// File: rtl/tilexy_link_arb.sv
// Egress arbiter for one mesh-link direction: round-robin with burst locking,
// pass-through aging override, credit-tracked output register.
module tilexy_link_arb
  import tilexy_pkg::*;
#(
  parameter int W        = WRREQ_W,
  parameter int CRED     = 8,
  parameter int MAX_WAIT = 15,
  parameter int DIR_IDX  = 0,
  localparam int CW      = $clog2(CRED + 1),
  localparam int AW      = $clog2(MAX_WAIT + 1)
) (
  input  logic               clk,
  input  logic               rst,
  tilexy_link_arb_if.slave   lnk,
  output arb_state_e         dbg_state_o,
  output logic [1:0]         dbg_owner_o,
  output logic [1:0]         dbg_rr_ptr_o,
  output logic [AW-1:0]      dbg_age_o,
  output logic [1:0]         dbg_dir_o
);
  arb_state_e    state_q, state_d;
  logic [2:0]    owner_oh_q, owner_oh_d;
  logic [1:0]    rr_ptr_q, rr_ptr_d;
  logic [AW-1:0] age_q, age_d;
  logic [CW-1:0] credits_q, credits_d;
  logic          cred_err_q, cred_err_d;
  logic          link_valid_q;
  logic [W-1:0]  link_data_q;

  logic [2:0] pick, ovr, grant;
  logic [1:0] gnt_idx;
  logic       gnt_any, gnt_last, has_credit, owner_valid;

  assign has_credit  = (credits_q != '0);
  assign owner_valid = |(owner_oh_q & lnk.req_valid);

  always_comb begin
    ovr           = '0;
    ovr[REQ_THRU] = (age_q == AW'(MAX_WAIT)) && lnk.req_valid[REQ_THRU];
  end

  tilexy_rr3 u_rr3 (
    .req_i (lnk.req_valid),
    .ptr_i (rr_ptr_q),
    .ovr_i (ovr),
    .gnt_o (pick)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Output logic: grant; held at zero while reset is asserted.
  always_comb begin
    grant = '0;
    if (rst && has_credit) begin
      unique case (state_q)
        ST_IDLE:           if (!lnk.link_stall) grant = pick;
        ST_BURST, ST_HOLD: grant = owner_oh_q & lnk.req_valid;
        default:           grant = '0;
      endcase
    end
  end

  assign gnt_any  = |grant;
  assign gnt_last = |(grant & lnk.req_last);
  assign gnt_idx  = oh_to_idx(grant);

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    owner_oh_d = owner_oh_q;
    unique case (state_q)
      ST_IDLE: if (gnt_any && !gnt_last) begin
        state_d    = ST_BURST;
        owner_oh_d = grant;
      end
      ST_BURST: begin
        if (!has_credit && owner_valid) state_d = ST_HOLD;
        else if (gnt_any && gnt_last)   state_d = ST_IDLE;
      end
      ST_HOLD: if (has_credit) state_d = (gnt_any && gnt_last) ? ST_IDLE : ST_BURST;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rr_ptr_d   = (gnt_any && gnt_last) ? rr_next(gnt_idx) : rr_ptr_q;
    age_d      = age_q;
    if (grant[REQ_THRU])                                       age_d = '0;
    else if (lnk.req_valid[REQ_THRU] && age_q != AW'(MAX_WAIT)) age_d = age_q + AW'(1);
    credits_d  = credits_q;
    cred_err_d = cred_err_q;
    if (gnt_any && !lnk.credit_ret) begin
      credits_d = credits_q - CW'(1);
    end else if (!gnt_any && lnk.credit_ret) begin
      // A return with every entry already free means the neighbour miscounted.
      if (credits_q == CW'(CRED)) cred_err_d = 1'b1;
      else                        credits_d  = credits_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_oh_q   <= '0;
      rr_ptr_q     <= REQ_LOCAL;
      age_q        <= '0;
      credits_q    <= CW'(CRED);
      cred_err_q   <= 1'b0;
      link_valid_q <= 1'b0;
      link_data_q  <= '0;
    end else begin
      owner_oh_q   <= owner_oh_d;
      rr_ptr_q     <= rr_ptr_d;
      age_q        <= age_d;
      credits_q    <= credits_d;
      cred_err_q   <= cred_err_d;
      link_valid_q <= gnt_any;
      if (gnt_any) link_data_q <= lnk.req_data[gnt_idx];
    end
  end

  assign lnk.req_grant  = grant;
  assign lnk.link_valid = link_valid_q;
  assign lnk.link_data  = link_data_q;
  assign lnk.credits    = credits_q;
  assign lnk.cred_err   = cred_err_q;

  assign dbg_state_o  = state_q;
  assign dbg_owner_o  = oh_to_idx(owner_oh_q);
  assign dbg_rr_ptr_o = rr_ptr_q;
  assign dbg_age_o    = age_q;
  assign dbg_dir_o    = 2'(DIR_IDX);
endmodule
